// File: rtl/scratch_mem_arbiter.sv
// Round-robin owner arbiter and port mux for the shared polynomial scratch RAMs.
// Optional watchdog on ownership length: define SCRATCH_ARB_WATCHDOG_EN.

module scratch_arb_lane #(
    parameter int AW = 11,
    parameter int DW = 13
) (
    input  logic          sel,
    input  logic          we_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          we,
    output logic [AW-1:0] rd_addr_m,
    output logic [AW-1:0] wr_addr_m,
    output logic [DW-1:0] wr_data_m,
    output logic          we_m
);
    assign rd_addr_m = sel ? rd_addr : '0;
    assign wr_addr_m = sel ? wr_addr : '0;
    assign wr_data_m = sel ? wr_data : '0;
    assign we_m      = sel & we_en & we;
endmodule

module scratch_mem_arbiter #(
    parameter int NREQ      = 2,
    parameter int AW        = 11,
    parameter int DW        = 13,
    parameter int WD_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    rel,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [2:0]         owner,
    input  logic [NREQ*AW-1:0] rd_addr_i,
    input  logic [NREQ*AW-1:0] wr_addr_i,
    input  logic [NREQ*DW-1:0] wr_data_i,
    input  logic [NREQ-1:0]    we_i,
    output logic [AW-1:0]      mem_rd_addr,
    output logic [AW-1:0]      mem_wr_addr,
    output logic [DW-1:0]      mem_wr_data,
    output logic               mem_we,
    output logic               wd_timeout
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

    state_t          state;
    logic [PW-1:0]   own_q, ptr_q, pick, ptr_nxt;
    logic [NREQ-1:0] pick_oh;
    logic            pick_vld;
    logic            own_rel;
    logic            wd_hit;

    // First pending requester at or after ptr, wrapping.
    always_comb begin
        int cand;
        cand     = 0;
        pick     = '0;
        pick_oh  = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!pick_vld && req[cand]) begin
                pick_vld      = 1'b1;
                pick          = PW'(cand);
                pick_oh[cand] = 1'b1;
            end
        end
    end

    assign ptr_nxt = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
    assign own_rel = rel[own_q];
    assign busy    = (state != IDLE);
    assign owner   = 3'(own_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            own_q <= '0;
            ptr_q <= '0;
            gnt   <= '0;
        end else begin
            case (state)
                IDLE: if (pick_vld) begin
                    state <= OWN;
                    own_q <= pick;
                    ptr_q <= ptr_nxt;
                    gnt   <= pick_oh;
                end
                OWN: if (own_rel || wd_hit) begin
                    state <= DRAIN;
                    gnt   <= '0;
                end
                DRAIN: state <= IDLE;
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

`ifdef SCRATCH_ARB_WATCHDOG_EN
    localparam int WCW = AW + 2;
    logic [WCW-1:0] wd_cnt;

    assign wd_hit = (state == OWN) && (wd_cnt == WCW'(WD_CYCLES - 1));

    // Counter only advances while ownership continues; any transition clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
        end else begin
            wd_timeout <= wd_hit && !own_rel;
            if (state == OWN && !own_rel && !wd_hit) wd_cnt <= wd_cnt + 1'b1;
            else                                     wd_cnt <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^WD_CYCLES;
    assign wd_hit     = 1'b0;
    assign wd_timeout = 1'b0;
`endif

    logic [NREQ-1:0]         sel;
    logic [NREQ-1:0][AW-1:0] rd_m, wr_m;
    logic [NREQ-1:0][DW-1:0] wd_m;
    logic [NREQ-1:0]         we_m;
    logic                    we_en;

    // DRAIN keeps the owner's addresses on the RAM but blocks writes.
    assign we_en = (state == OWN);

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign sel[g] = (state != IDLE) && (own_q == PW'(g));
        scratch_arb_lane #(.AW(AW), .DW(DW)) u_lane (
            .sel       (sel[g]),
            .we_en     (we_en),
            .rd_addr   (rd_addr_i[g*AW +: AW]),
            .wr_addr   (wr_addr_i[g*AW +: AW]),
            .wr_data   (wr_data_i[g*DW +: DW]),
            .we        (we_i[g]),
            .rd_addr_m (rd_m[g]),
            .wr_addr_m (wr_m[g]),
            .wr_data_m (wd_m[g]),
            .we_m      (we_m[g])
        );
    end

    always_comb begin
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_we      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            mem_rd_addr |= rd_m[k];
            mem_wr_addr |= wr_m[k];
            mem_wr_data |= wd_m[k];
            mem_we      |= we_m[k];
        end
    end
endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Bench for scratch_mem_arbiter: directed handshake cases plus randomized traffic
// against an ownership-level reference model.
module tb_scratch_mem_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 11;
    localparam int DW   = 13;
    localparam int WD   = 16;
`ifdef SCRATCH_ARB_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]    req, rel, we_i, gnt;
    logic               busy, mem_we, wd_timeout;
    logic [2:0]         owner;
    logic [NREQ*AW-1:0] rd_addr_i, wr_addr_i;
    logic [NREQ*DW-1:0] wr_data_i;
    logic [AW-1:0]      mem_rd_addr, mem_wr_addr;
    logic [DW-1:0]      mem_wr_data;

    always #5 clk = ~clk;

    scratch_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WD_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .gnt(gnt), .busy(busy), .owner(owner),
        .rd_addr_i(rd_addr_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .we_i(we_i),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_we(mem_we), .wd_timeout(wd_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who holds the RAM, whether a release cycle is pending.
    int m_owner, m_ptr, m_cycles;
    bit m_held, m_drain, m_pulse;

    task automatic model_reset();
        m_owner = 0; m_ptr = 0; m_cycles = 0;
        m_held = 0; m_drain = 0; m_pulse = 0;
    endtask

    task automatic model_edge();
        m_pulse = 0;
        if (m_held) begin
            m_cycles++;
            if (rel[m_owner]) begin
                m_held = 0; m_drain = 1;
            end else if (WD_ON && m_cycles == WD) begin
                m_held = 0; m_drain = 1; m_pulse = 1;
            end
        end else if (m_drain) begin
            m_drain = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (m_ptr + i) % NREQ;
                if (req[k]) begin
                    m_owner = k; m_held = 1; m_cycles = 0;
                    m_ptr = (k + 1) % NREQ;
                    break;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [NREQ-1:0] eg;
        bit eb;
        eg = '0;
        if (m_held) eg[m_owner] = 1'b1;
        eb = m_held || m_drain;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'(eb));
        chk("owner", 32'(owner), m_owner);
        chk("mem_rd_addr", 32'(mem_rd_addr), eb ? 32'(rd_addr_i[m_owner*AW +: AW]) : 0);
        chk("mem_wr_addr", 32'(mem_wr_addr), eb ? 32'(wr_addr_i[m_owner*AW +: AW]) : 0);
        chk("mem_wr_data", 32'(mem_wr_data), eb ? 32'(wr_data_i[m_owner*DW +: DW]) : 0);
        chk("mem_we", 32'(mem_we), m_held ? 32'(we_i[m_owner]) : 0);
        chk("wd_timeout", 32'(wd_timeout), 32'(m_pulse));
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; rel = '0; we_i = '0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    int pulses;

    initial begin
        rst = 1'b1; req = '0; rel = '0; we_i = '0;
        rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0;
        model_reset();
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_wd", 32'(wd_timeout), 0);
        chk("rst_rd_addr", 32'(mem_rd_addr), 0);
        do_reset();

        // Single requester: one-cycle grant latency, zero-latency address mux.
        req = 3'b001; rd_addr_i[0 +: AW] = 11'd5;
        #1 chk("t1_gnt_pre", 32'(gnt), 0);
        cyc();
        chk("t1_gnt", 32'(gnt), 32'b001);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_rd_addr", 32'(mem_rd_addr), 5);
        rel = 3'b001; cyc(); rel = '0; req = '0; cyc(); cyc();

        // Two requesters from reset, round-robin hand-over.
        do_reset();
        req = 3'b011; cyc();
        chk("t2_gnt0", 32'(gnt), 32'b001);
        rel = 3'b001; cyc(); rel = '0;
        chk("t2_drain", 32'(gnt), 0);
        cyc();
        chk("t2_idle", 32'(gnt), 0);
        cyc();
        chk("t2_gnt1", 32'(gnt), 32'b010);
        rel = 3'b010; cyc(); rel = '0; cyc(); cyc();
        chk("t2_back0", 32'(gnt), 32'b001);

        // Non-owner write enable and release are ignored.
        we_i = 3'b010; wr_addr_i[AW +: AW] = 11'd7;
        #1 chk("t3_we", 32'(mem_we), 0);
        chk("t3_wr_addr", 32'(mem_wr_addr), 0);
        rel = 3'b010; cyc(); rel = '0;
        chk("t3_keep", 32'(gnt), 32'b001);
        cyc();
        chk("t3_keep2", 32'(gnt), 32'b001);
        we_i = '0;

        // rel and req from the owner together: rel wins, other requester served next.
        rel = 3'b001; cyc(); rel = '0;
        chk("t4_drain_busy", 32'(busy), 1);
        chk("t4_drain_gnt", 32'(gnt), 0);
        cyc(); cyc();
        chk("t4_gnt1", 32'(gnt), 32'b010);
        rel = 3'b010; cyc(); rel = '0; req = '0; cyc(); cyc();

        // Asynchronous reset while owning with a write active.
        req = 3'b001; we_i = 3'b001; cyc();
        chk("t5_we_on", 32'(mem_we), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_gnt", 32'(gnt), 0);
        chk("t5_we", 32'(mem_we), 0);
        chk("t5_busy", 32'(busy), 0);
        model_reset();
        we_i = '0;
        @(negedge clk);
        rst = 1'b0; req = 3'b011;
        @(posedge clk);
        model_edge();
        #1;
        chk("t5_ptr0", 32'(gnt), 32'b001);

        // Ownership held without release.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (wd_timeout) pulses++;
        end
        chk("t6_pulses", pulses, WD_ON ? 1 : 0);
        chk("t6_gnt", 32'(gnt), WD_ON ? 32'b010 : 32'b001);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req       = NREQ'($urandom);
            rel       = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            if (m_held && $urandom_range(0, 5) == 0) rel[m_owner] = 1'b1;
            we_i      = NREQ'($urandom);
            rd_addr_i = (NREQ*AW)'({$urandom, $urandom});
            wr_addr_i = (NREQ*AW)'({$urandom, $urandom});
            wr_data_i = (NREQ*DW)'({$urandom, $urandom});
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
